mem_req_queue: RTL and testbench

- Sits directly downstream of the core's registered memory-request port and upstream of the memory/interconnect.
- Buffers the core's un-backpressured request pulses in a FIFO and issues them to memory under a vld/ready handshake.
- Limits outstanding (issued, unanswered) requests and registers memory responses back to the core.
- Gives the core an early almost-full warning so it can withhold arbiter grants.

---
 rtl/mem_req_queue.sv | 148 ++++++++++++++
 tb/tb_mem_req_queue.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_queue.sv
// rtl/mem_req_queue.sv - memory request FIFO with outstanding limit and registered response path
// Optional same-cycle bypass of an empty queue: MEM_REQ_QUEUE_BYPASS_EN.
module mem_req_queue #(
    parameter int DEPTH           = 8,
    parameter int MAX_OUTSTANDING = 16,
    parameter int AFULL_MARGIN    = 2,
    parameter int ID_W            = 8,
    parameter int DATA_W          = 32,
    localparam int PW             = $clog2(DEPTH),
    localparam int CW             = PW + 1,
    localparam int OW             = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              core_req_vld_i,
    input  logic [ID_W-1:0]   core_req_id_i,
    input  logic [DATA_W-1:0] core_req_data_i,
    output logic              core_rsp_vld_o,
    output logic [ID_W-1:0]   core_rsp_id_o,
    output logic [DATA_W-1:0] core_rsp_data_o,
    output logic              almost_full_o,
    output logic              overflow_o,
    output logic              mem_req_vld_o,
    output logic [ID_W-1:0]   mem_req_id_o,
    output logic [DATA_W-1:0] mem_req_data_o,
    input  logic              mem_ready_i,
    input  logic              mem_rsp_vld_i,
    input  logic [ID_W-1:0]   mem_rsp_id_i,
    input  logic [DATA_W-1:0] mem_rsp_data_i,
    output logic [OW-1:0]     outstanding_o,
    output logic [1:0]        state_o
);
    localparam int EW = ID_W + DATA_W;

    typedef enum logic [1:0] {
        ST_EMPTY     = 2'd0,
        ST_ACTIVE    = 2'd1,
        ST_THROTTLED = 2'd2,
        ST_FULL      = 2'd3
    } state_t;

    logic [EW-1:0]     fifo_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [OW-1:0]     out_q, out_d;
    logic              overflow_q, overflow_d;
    logic              afull_q, afull_d;
    logic              rsp_vld_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic [DATA_W-1:0] rsp_data_q;
    state_t            state_q, state_d;

    logic              can_issue, full, fifo_vld, bypass, deq, issue, enq;
    logic [EW-1:0]     head, req_pld;

    always_comb begin
        head       = fifo_q[rd_ptr_q];
        can_issue  = out_q < OW'(MAX_OUTSTANDING);
        full       = count_q == CW'(DEPTH);
        fifo_vld   = (count_q != '0) && can_issue;
`ifdef MEM_REQ_QUEUE_BYPASS_EN
        bypass     = (count_q == '0) && can_issue && core_req_vld_i;
`else
        bypass     = 1'b0;
`endif
        deq        = fifo_vld && mem_ready_i;
        issue      = (fifo_vld || bypass) && mem_ready_i;
        // A bypassed request that memory takes immediately never touches the FIFO.
        enq        = core_req_vld_i && (!full || deq) && !(bypass && mem_ready_i);
        overflow_d = overflow_q || (core_req_vld_i && full && !deq);

        wr_ptr_d   = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = deq ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(enq) - CW'(deq);

        if (issue && mem_rsp_vld_i) begin
            out_d = out_q;
        end else if (issue) begin
            out_d = out_q + OW'(1);
        end else if (mem_rsp_vld_i && (out_q != '0)) begin
            out_d = out_q - OW'(1);
        end else begin
            out_d = out_q;
        end

        afull_d = (CW'(DEPTH) - count_d) <= CW'(AFULL_MARGIN);

        if (count_d == '0) begin
            state_d = ST_EMPTY;
        end else if (count_d == CW'(DEPTH)) begin
            state_d = ST_FULL;
        end else if (out_d == OW'(MAX_OUTSTANDING)) begin
            state_d = ST_THROTTLED;
        end else begin
            state_d = ST_ACTIVE;
        end

        req_pld = '0;
        if (fifo_vld) begin
            req_pld = head;
        end else if (bypass) begin
            req_pld = {core_req_id_i, core_req_data_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            fifo_q[wr_ptr_q] <= {core_req_id_i, core_req_data_i};
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            out_q      <= '0;
            overflow_q <= 1'b0;
            afull_q    <= 1'b0;
            rsp_vld_q  <= 1'b0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
            state_q    <= ST_EMPTY;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            out_q      <= out_d;
            overflow_q <= overflow_d;
            afull_q    <= afull_d;
            rsp_vld_q  <= mem_rsp_vld_i;
            rsp_id_q   <= mem_rsp_id_i;
            rsp_data_q <= mem_rsp_data_i;
            state_q    <= state_d;
        end
    end

    assign mem_req_vld_o   = fifo_vld || bypass;
    assign mem_req_id_o    = req_pld[EW-1:DATA_W];
    assign mem_req_data_o  = req_pld[DATA_W-1:0];
    assign core_rsp_vld_o  = rsp_vld_q;
    assign core_rsp_id_o   = rsp_id_q;
    assign core_rsp_data_o = rsp_data_q;
    assign almost_full_o   = afull_q;
    assign overflow_o      = overflow_q;
    assign outstanding_o   = out_q;
    assign state_o         = state_q;
endmodule

// File: tb/tb_mem_req_queue.sv
// tb/tb_mem_req_queue.sv - self-checking bench for mem_req_queue
module tb_mem_req_queue;
    localparam int DEPTH  = 8;
    localparam int MAXO   = 16;
    localparam int MARGIN = 2;

    logic        clk, reset;
    logic        cv, rdy, rv;
    logic [7:0]  cid, rid;
    logic [31:0] cdata, rdata;
    logic        rsp_vld, af, ov, mv;
    logic [7:0]  rsp_id, mid;
    logic [31:0] rsp_data, mdata;
    logic [4:0]  outst;
    logic [1:0]  state;

    mem_req_queue dut (
        .clk_i(clk), .reset_i(reset),
        .core_req_vld_i(cv), .core_req_id_i(cid), .core_req_data_i(cdata),
        .core_rsp_vld_o(rsp_vld), .core_rsp_id_o(rsp_id), .core_rsp_data_o(rsp_data),
        .almost_full_o(af), .overflow_o(ov),
        .mem_req_vld_o(mv), .mem_req_id_o(mid), .mem_req_data_o(mdata),
        .mem_ready_i(rdy),
        .mem_rsp_vld_i(rv), .mem_rsp_id_i(rid), .mem_rsp_data_i(rdata),
        .outstanding_o(outst), .state_o(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: queue contents plus scalar bookkeeping.
    logic [39:0] q[$];
    int          m_out;
    bit          m_ov, m_af, m_rv;
    logic [39:0] m_rp;

    bit          s_mv, s_af, s_ov, s_rv, s_issue;
    logic [7:0]  s_mid, s_rid;
    logic [4:0]  s_out;

    typedef struct {
        bit         cv;
        logic [7:0] cid;
        bit         rdy;
        bit         rv;
        bit         e_mv;
        logic [7:0] e_mid;
        bit         e_af;
        bit         e_ov;
        int         e_out;
        bit         e_rv;
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] tdata(input logic [7:0] id);
        return {24'hA5A5A5, id};
    endfunction

    task automatic model_clear();
        q.delete();
        m_out = 0;
        m_ov  = 0;
        m_af  = 0;
        m_rv  = 0;
        m_rp  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        cv = 0; cid = 0; cdata = 0; rdy = 0; rv = 0; rid = 0; rdata = 0;
        model_clear();
        #1;
        chk("rst_mem_vld", mv, 0);
        chk("rst_outst", outst, 0);
        chk("rst_afull", af, 0);
        chk("rst_ovf", ov, 0);
        chk("rst_rsp_vld", rsp_vld, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drive(input bit c_v, input logic [7:0] c_id, input logic [31:0] c_d,
                         input bit r, input bit r_v, input logic [7:0] r_id, input logic [31:0] r_d);
        bit ev, byp;
        logic [39:0] ep;
        @(negedge clk);
        cv = c_v; cid = c_id; cdata = c_d; rdy = r; rv = r_v; rid = r_id; rdata = r_d;
        #1;
        byp = 0;
        ev  = (q.size() > 0) && (m_out < MAXO);
        ep  = ev ? q[0] : '0;
`ifdef MEM_REQ_QUEUE_BYPASS_EN
        if (q.size() == 0 && m_out < MAXO && c_v) begin
            ev = 1; byp = 1; ep = {c_id, c_d};
        end
`endif
        s_mv = mv; s_mid = mid; s_af = af; s_ov = ov; s_out = outst;
        s_rv = rsp_vld; s_rid = rsp_id; s_issue = mv && r;
        chk("mem_vld", mv, ev);
        if (ev) chk("mem_pld", {mid, mdata}, ep);
        chk("almost_full", af, m_af);
        chk("overflow", ov, m_ov);
        chk("outstanding", outst, m_out);
        chk("rsp_vld", rsp_vld, m_rv);
        if (m_rv) chk("rsp_pld", {rsp_id, rsp_data}, m_rp);
        @(posedge clk);
        if (ev && r && !byp) q.delete(0);
        if (c_v && !(byp && r)) begin
            if (q.size() < DEPTH) q.push_back({c_id, c_d});
            else m_ov = 1;
        end
        if (ev && r && r_v) m_out = m_out;
        else if (ev && r) m_out = m_out + 1;
        else if (r_v && m_out > 0) m_out = m_out - 1;
        m_af = (DEPTH - q.size()) <= MARGIN;
        m_rv = r_v;
        m_rp = {r_id, r_d};
    endtask

    task automatic idle(input bit r);
        drive(0, 8'h0, 32'h0, r, 0, 8'h0, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int issued;
        int p_rdy;
        bit e_mv;
        // cv cid rdy rv | mem_vld mem_id afull ovf outst rsp_vld
        tbl[0]  = '{1, 8'd0, 0, 0, 0, 8'd0, 0, 0, 0, 0};
        tbl[1]  = '{1, 8'd1, 0, 0, 1, 8'd0, 0, 0, 0, 0};
        tbl[2]  = '{1, 8'd2, 0, 0, 1, 8'd0, 0, 0, 0, 0};
        tbl[3]  = '{1, 8'd3, 0, 0, 1, 8'd0, 0, 0, 0, 0};
        tbl[4]  = '{1, 8'd4, 0, 0, 1, 8'd0, 0, 0, 0, 0};
        tbl[5]  = '{1, 8'd5, 0, 0, 1, 8'd0, 0, 0, 0, 0};
        tbl[6]  = '{1, 8'd6, 0, 0, 1, 8'd0, 1, 0, 0, 0};
        tbl[7]  = '{1, 8'd7, 0, 0, 1, 8'd0, 1, 0, 0, 0};
        tbl[8]  = '{1, 8'd8, 0, 0, 1, 8'd0, 1, 0, 0, 0};
        tbl[9]  = '{1, 8'd9, 1, 0, 1, 8'd0, 1, 1, 0, 0};
        tbl[10] = '{0, 8'd0, 1, 0, 1, 8'd1, 1, 1, 1, 0};
        tbl[11] = '{0, 8'd0, 1, 0, 1, 8'd2, 1, 1, 2, 0};
        tbl[12] = '{0, 8'd0, 1, 0, 1, 8'd3, 1, 1, 3, 0};
        tbl[13] = '{0, 8'd0, 1, 0, 1, 8'd4, 0, 1, 4, 0};
        tbl[14] = '{0, 8'd0, 1, 0, 1, 8'd5, 0, 1, 5, 0};
        tbl[15] = '{0, 8'd0, 1, 0, 1, 8'd6, 0, 1, 6, 0};
        tbl[16] = '{0, 8'd0, 1, 0, 1, 8'd7, 0, 1, 7, 0};
        tbl[17] = '{0, 8'd0, 1, 1, 1, 8'd9, 0, 1, 8, 0};
        tbl[18] = '{0, 8'd0, 0, 0, 0, 8'd0, 0, 1, 8, 1};
        tbl[19] = '{0, 8'd0, 0, 1, 0, 8'd0, 0, 1, 8, 0};
        tbl[20] = '{0, 8'd0, 0, 0, 0, 8'd0, 0, 1, 7, 1};

        reset = 1'b1;
        cv = 0; cid = 0; cdata = 0; rdy = 0; rv = 0; rid = 0; rdata = 0;
        model_clear();
        do_reset();

        // Fill, overflow, full-with-dequeue, response-with-issue
        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].cv, tbl[i].cid, tdata(tbl[i].cid), tbl[i].rdy, tbl[i].rv, 8'h33, 32'h1234);
            e_mv = tbl[i].e_mv;
`ifdef MEM_REQ_QUEUE_BYPASS_EN
            if (i == 0) e_mv = 1;
`endif
            chk("tbl_mem_vld", s_mv, e_mv);
            if (e_mv) chk("tbl_mem_id", s_mid, tbl[i].e_mid);
            chk("tbl_afull", s_af, tbl[i].e_af);
            chk("tbl_ovf", s_ov, tbl[i].e_ov);
            chk("tbl_outst", s_out, tbl[i].e_out);
            chk("tbl_rsp_vld", s_rv, tbl[i].e_rv);
        end

        // Single request latency
        do_reset();
        for (int i = 0; i < 10; i++) idle(1);
        drive(1, 8'd5, tdata(8'd5), 1, 0, 8'h0, 32'h0);
`ifdef MEM_REQ_QUEUE_BYPASS_EN
        chk("single_bypass_vld", s_mv, 1);
        idle(1);
        chk("single_out_11", s_out, 1);
`else
        idle(1);
        chk("single_vld_11", s_mv, 1);
        chk("single_id_11", s_mid, 5);
`endif
        idle(1);
        chk("single_out_12", s_out, 1);
        for (int i = 13; i < 20; i++) idle(1);
        drive(0, 8'h0, 32'h0, 1, 1, 8'd5, 32'hBEEF);
        idle(1);
        chk("single_rsp_21", s_rv, 1);
        chk("single_rsp_id", s_rid, 5);
        chk("single_out_21", s_out, 0);

        // Throttle at MAX_OUTSTANDING
        do_reset();
        issued = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1, 8'(i), tdata(8'(i)), 1, 0, 8'h0, 32'h0);
            issued += int'(s_issue);
        end
        for (int i = 0; i < 6; i++) begin
            idle(1);
            issued += int'(s_issue);
        end
        chk("thr_issued", issued, 16);
        chk("thr_stall_vld", s_mv, 0);
        chk("thr_outst", s_out, 16);
        drive(0, 8'h0, 32'h0, 1, 1, 8'h1, 32'h0);
        idle(1);
        chk("thr_one_more", s_mv, 1);
        chk("thr_one_more_id", s_mid, 16);
        idle(1);
        chk("thr_stall_again", s_mv, 0);
        chk("thr_outst_again", s_out, 16);

        // Reset mid-flight with queued and outstanding requests
        do_reset();
        drive(1, 8'hA0, tdata(8'hA0), 0, 0, 8'h0, 32'h0);
        drive(1, 8'hA1, tdata(8'hA1), 0, 0, 8'h0, 32'h0);
        idle(1);
        idle(1);
        for (int i = 0; i < 3; i++) drive(1, 8'(8'hB0 + i), tdata(8'(8'hB0 + i)), 0, 0, 8'h0, 32'h0);
        idle(0);
        chk("mid_pre_outst", s_out, 2);
        @(negedge clk);
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        chk("mid_rst_mem_vld", mv, 0);
        chk("mid_rst_outst", outst, 0);
        chk("mid_rst_afull", af, 0);
        chk("mid_rst_ovf", ov, 0);
        chk("mid_rst_rsp", rsp_vld, 0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 8'h0, 32'h0, 0, 1, 8'hEE, 32'h5555);
        idle(0);
        chk("mid_stray_rsp", s_rv, 1);
        chk("mid_stray_id", s_rid, 8'hEE);
        chk("mid_stray_outst", s_out, 0);

        // Randomized traffic against the model
        for (int ph = 0; ph < 4; ph++) begin
            do_reset();
            p_rdy = (ph == 0) ? 90 : (ph == 1) ? 50 : (ph == 2) ? 20 : 97;
            for (int n = 0; n < 800; n++) begin
                bit c, r, v;
                logic [7:0] id;
                c  = ($urandom % 100) < 60;
                r  = ($urandom % 100) < p_rdy;
                v  = (m_out > 0) ? (($urandom % 100) < 40) : (($urandom % 100) < 3);
                id = 8'($urandom);
                drive(c, id, $urandom, r, v, 8'($urandom), $urandom);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
